simon_autoplayer: RTL and testbench

//   Automated player for the simon game: the other end of its led/btn interface.

---
 rtl/simon_autoplayer_if.sv | 16 +
 rtl/simon_autoplayer.sv | 217 +++++++++++++++++++++
 tb/tb_simon_autoplayer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/simon_autoplayer_if.sv
// Game-side link of the simon autoplayer: LEDs from the game, buttons to it.
// master = autoplayer (reads led_in, drives btn); slave = game side.
interface simon_autoplayer_if;
  logic [3:0] led_in;
  logic [3:0] btn;

  modport master (
    input  led_in,
    output btn
  );

  modport slave (
    output led_in,
    input  btn
  );
endinterface

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: records the game's LED playback, replays it as presses.
// Ports: clk/rst, ticks_per_milli, enable, start, miss_at, game link, status.
module simon_autoplayer #(
  parameter int DEPTH    = 128,
  parameter int PRESS_MS = 100,
  parameter int GAP_MS   = 300,
  parameter int IDLE_MS  = 250,
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   ticks_per_milli,
  input  logic          enable,
  input  logic          start,
  input  logic [LW-1:0] miss_at,
  simon_autoplayer_if.master game,
  output logic [LW-1:0] level,
  output logic          busy,
  output logic          game_over,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] ONE = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_PRESS,
    S_OBSERVE,
    S_REPLAY_PRESS,
    S_REPLAY_GAP,
    S_GAME_OVER,
    S_OVERFLOW
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    btn_q, btn_d;
  logic [LW-1:0] level_q, level_d;
  logic          busy_q, busy_d;
  logic          go_q, go_d;
  logic          ovf_q, ovf_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   pre_q, pre_d;
  logic [15:0]   ms_q, ms_d;
  logic [3:0]    led_prev_q, led_prev_d;

  logic [1:0]    seq_q [DEPTH];
  logic          seq_we;
  logic [1:0]    seq_wdata;

  logic [3:0]    led;
  logic          multi;
  logic          onehot;
  logic [1:0]    led_idx;
  logic [15:0]   tpm_last;
  logic          pre_last;
  logic          press_done;
  logic          gap_done;
  logic          idle_done;
  logic          tick_clr;
  logic          miss;
  logic [1:0]    sel;

  assign led      = game.led_in;
  assign multi    = |(led & (led - 4'd1));
  assign onehot   = (led != 4'd0) && !multi;
  assign tpm_last = (ticks_per_milli < 16'd2) ? 16'd0
                                              : ticks_per_milli - 16'd1;
  assign pre_last   = pre_q >= tpm_last;
  assign press_done = pre_last && (ms_q >= 16'(PRESS_MS - 1));
  assign gap_done   = pre_last && (ms_q >= 16'(GAP_MS - 1));
  assign idle_done  = pre_last && (ms_q >= 16'(IDLE_MS - 1));

  always_comb begin
    led_idx = 2'd0;
    priority case (1'b1)
      led[0]:  led_idx = 2'd0;
      led[1]:  led_idx = 2'd1;
      led[2]:  led_idx = 2'd2;
      led[3]:  led_idx = 2'd3;
      default: led_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    go_d       = go_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    led_prev_d = led;
    seq_we     = 1'b0;
    seq_wdata  = led_idx;
    btn_d      = 4'd0;
    miss       = 1'b0;
    sel        = 2'd0;

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_GAME_OVER, S_OVERFLOW: begin
          if (start) begin
            state_d  = S_START_PRESS;
            wr_ptr_d = '0;
            go_d     = 1'b0;
            ovf_d    = 1'b0;
          end
        end
        S_START_PRESS: begin
          if (press_done) state_d = S_OBSERVE;
        end
        S_OBSERVE: begin
          if (multi) begin
            state_d = S_GAME_OVER;
          end else if (onehot && led != led_prev_q) begin
            if (wr_ptr_q == LW'(DEPTH)) begin
              state_d = S_OVERFLOW;
            end else begin
              seq_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + ONE;
            end
          end else if (led == 4'd0 && idle_done
                       && wr_ptr_q != '0) begin
            state_d  = S_REPLAY_PRESS;
            rd_ptr_d = '0;
          end
        end
        S_REPLAY_PRESS: begin
          if (press_done) state_d = S_REPLAY_GAP;
        end
        S_REPLAY_GAP: begin
          if (multi) begin
            state_d = S_GAME_OVER;
          end else if (gap_done) begin
            rd_ptr_d = rd_ptr_q + ONE;
            if (rd_ptr_q + ONE == wr_ptr_q) begin
              level_d  = wr_ptr_q;
              wr_ptr_d = '0;
              state_d  = S_OBSERVE;
            end else begin
              state_d = S_REPLAY_PRESS;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_GAME_OVER) go_d = 1'b1;
    if (state_d == S_OVERFLOW)  ovf_d = 1'b1;

    // Button drive follows the next state so every output is registered.
    if (state_d == S_START_PRESS) btn_d = 4'b0001;
    if (state_d == S_REPLAY_PRESS) begin
      miss = (miss_at != '0) && (miss_at == wr_ptr_q)
             && (rd_ptr_d == wr_ptr_q - ONE);
      sel   = seq_q[rd_ptr_d[AW-1:0]] + {1'b0, miss};
      btn_d = 4'b0001 << sel;
    end

    busy_d = (state_d == S_START_PRESS) || (state_d == S_OBSERVE)
          || (state_d == S_REPLAY_PRESS) || (state_d == S_REPLAY_GAP);

    // Timers restart on state entry; lit LEDs restart the dark timer.
    tick_clr = (state_d != state_q)
            || (state_q == S_OBSERVE && led != 4'd0);
    pre_d = (tick_clr || pre_last) ? 16'd0 : pre_q + 16'd1;
    if (tick_clr)
      ms_d = 16'd0;
    else if (pre_last && ms_q != 16'hFFFF)
      ms_d = ms_q + 16'd1;
    else
      ms_d = ms_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      btn_q      <= 4'd0;
      level_q    <= '0;
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pre_q      <= 16'd0;
      ms_q       <= 16'd0;
      led_prev_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
      go_q       <= go_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pre_q      <= pre_d;
      ms_q       <= ms_d;
      led_prev_q <= led_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    if (seq_we) seq_q[wr_ptr_q[AW-1:0]] <= seq_wdata;
  end

  assign game.btn  = btn_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign game_over = go_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed bench for simon_autoplayer (DEPTH=4, short timings).
// Drives the game link and checks button timing and status flags.
module tb_simon_autoplayer;

  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   tpm;
  logic          enable;
  logic          start;
  logic [LW-1:0] miss_at;
  logic [LW-1:0] level;
  logic          busy;
  logic          go;
  logic          ovf;

  int n_checks = 0;
  int n_err    = 0;

  simon_autoplayer_if gif ();

  simon_autoplayer #(
    .DEPTH(4), .PRESS_MS(2), .GAP_MS(3), .IDLE_MS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ticks_per_milli(tpm),
    .enable(enable),
    .start(start),
    .miss_at(miss_at),
    .game(gif),
    .level(level),
    .busy(busy),
    .game_over(go),
    .overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_len(input logic [3:0] v, output int n);
    n = 0;
    while (gif.btn == v && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic play(input logic [3:0] v);
    gif.led_in = v;
    repeat (10) tick();
    gif.led_in = 4'b0000;
  endtask

  task automatic wait_dark(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (gif.btn == 4'b0000 && n < 40);
    check(tag, n, 20);
  endtask

  task automatic expect_step(input string tag, input logic [3:0] v);
    int n;
    run_len(v, n);
    check({tag, "_press"}, n, 8);
    repeat (11) tick();
    check({tag, "_gap"}, {28'd0, gif.btn}, 0);
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] pats [5];
    pats = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1; tpm = 16'd4; enable = 1'b1; start = 1'b0;
    miss_at = '0; gif.led_in = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_btn",   {28'd0, gif.btn}, 0);
    check("rst_level", {29'd0, level}, 0);
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_go",    {31'd0, go}, 0);
    check("rst_ovf",   {31'd0, ovf}, 0);

    pulse_start();
    check("start_btn",  {28'd0, gif.btn}, 32'h1);
    check("start_busy", {31'd0, busy}, 1);
    run_len(4'b0001, n);
    check("start_len", n, 8);
    check("start_rel", {28'd0, gif.btn}, 0);

    play(4'b0100);
    repeat (6) tick();
    play(4'b0001);
    wait_dark("idle_len1");
    expect_step("g1s1", 4'b0100);
    check("lvl_mid", {29'd0, level}, 0);
    expect_step("g1s2", 4'b0001);
    check("lvl2", {29'd0, level}, 2);
    check("obs_busy", {31'd0, busy}, 1);

    play(4'b1000);
    repeat (6) tick();
    play(4'b0010);
    repeat (6) tick();
    play(4'b0010);
    wait_dark("idle_len2");
    expect_step("g2s1", 4'b1000);
    expect_step("g2s2", 4'b0010);
    expect_step("g2s3", 4'b0010);
    check("lvl3", {29'd0, level}, 3);

    pulse_start();
    check("start_ign", {28'd0, gif.btn}, 0);
    enable = 1'b0;
    tick();
    check("dis_busy", {31'd0, busy}, 0);
    enable = 1'b1;
    miss_at = 3'd2;
    pulse_start();
    run_len(4'b0001, n);
    check("restart_len", n, 8);
    play(4'b0100);
    repeat (6) tick();
    play(4'b0001);
    wait_dark("idle_len3");
    expect_step("m1", 4'b0100);
    run_len(4'b0010, n);
    check("miss_press", n, 8);
    repeat (2) tick();
    gif.led_in = 4'b1111;
    tick();
    check("go_flag", {31'd0, go}, 1);
    check("go_btn",  {28'd0, gif.btn}, 0);
    check("go_busy", {31'd0, busy}, 0);
    gif.led_in = 4'b0000;
    miss_at = '0;

    pulse_start();
    check("go_clr",   {31'd0, go}, 0);
    check("go_start", {28'd0, gif.btn}, 32'h1);
    run_len(4'b0001, n);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ovf_pre", {31'd0, ovf}, 0);
      gif.led_in = pats[i];
      tick();
      if (i < 4) begin
        tick();
        gif.led_in = 4'b0000;
        tick(); tick();
      end
    end
    check("ovf_flag", {31'd0, ovf}, 1);
    check("ovf_busy", {31'd0, busy}, 0);
    gif.led_in = 4'b0000;
    pulse_start();
    check("ovf_clr", {31'd0, ovf}, 0);
    check("ovf_btn", {28'd0, gif.btn}, 32'h1);

    run_len(4'b0001, n);
    play(4'b0100);
    wait_dark("idle_len4");
    repeat (3) tick();
    enable = 1'b0;
    tick();
    check("en_btn",  {28'd0, gif.btn}, 0);
    check("en_busy", {31'd0, busy}, 0);
    enable = 1'b1;
    tick();
    check("en_idle", {31'd0, busy}, 0);
    check("en_lvl",  {29'd0, level}, 3);

    pulse_start();
    run_len(4'b0001, n);
    play(4'b0010);
    wait_dark("idle_len5");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_btn",   {28'd0, gif.btn}, 0);
    check("rst2_level", {29'd0, level}, 0);
    check("rst2_busy",  {31'd0, busy}, 0);

    tpm = 16'd0;
    pulse_start();
    run_len(4'b0001, n);
    check("tpm0_len", n, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
